logic_unit_pipe: RTL and testbench

//   Parametrised, pipelined bitwise logic unit for the ALU datapath. Successor to the

---
 rtl/logic_unit_pipe.sv | 204 ++++++++++++++++++++
 tb/tb_logic_unit_pipe.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_pipe.sv
// -----------------------------------------------------------------------------
// logic_unit_pipe
//
// Pipelined bitwise logic unit for the ALU datapath. One of eight logic ops is
// evaluated combinationally on the incoming operands. The result, its zero and
// parity flags and the caller's tag then travel through STAGES elastic
// register stages to the output port.
//
// Parameters
//   WIDTH   operand/result width in bits (>= 1)
//   STAGES  number of pipeline register stages, 1..8
//   TAG_W   width of the tag sideband (>= 1)
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   flush      in   synchronous flush, drops every in-flight op
//   in_valid   in   operands/op/tag valid
//   in_ready   out  unit accepts the op this cycle
//   op         in   operation select
//                     000 AND   001 OR    010 XOR   011 XNOR
//                     100 NOR   101 NAND  110 ANDN (a & ~b)  111 PASS_A
//   a, b       in   operands
//   in_tag     in   tag, returned unchanged with the result
//   out_valid  out  result valid
//   out_ready  in   downstream accepts the result
//   result     out  operation result
//   zero       out  result == 0
//   parity     out  XOR-reduction of result (1 = odd number of ones)
//   out_tag    out  tag of the presented result
//   busy       out  OR of all stage valid bits
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high, on either side. in_ready does not depend on in_valid, and out_valid
// does not depend on out_ready. A source holding in_valid keeps its op, a, b
// and in_tag stable until the transfer. While out_valid is high and out_ready
// is low, out_valid, result, zero, parity and out_tag hold stable.
// -----------------------------------------------------------------------------
module logic_unit_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             parity,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    generate
        if (STAGES < 1 || STAGES > 8) begin : g_bad_stages
            $error("logic_unit_pipe: STAGES must be in 1..8");
        end
    endgenerate

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_XNOR = 3'b011;
    localparam logic [2:0] OP_NOR  = 3'b100;
    localparam logic [2:0] OP_NAND = 3'b101;
    localparam logic [2:0] OP_ANDN = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

    // ------------------------------------------------------------------
    // Operation and flags, evaluated ahead of stage 0.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_res;
    logic             w_zero;
    logic             w_par;

    always_comb begin
        w_res = a;
        case (op)
            OP_AND:  w_res = a & b;
            OP_OR:   w_res = a | b;
            OP_XOR:  w_res = a ^ b;
            OP_XNOR: w_res = ~(a ^ b);
            OP_NOR:  w_res = ~(a | b);
            OP_NAND: w_res = ~(a & b);
            OP_ANDN: w_res = a & ~b;
            OP_PASS: w_res = a;
            default: w_res = a;
        endcase
    end

    assign w_zero = (w_res == '0);
    assign w_par  = ^w_res;

    // ------------------------------------------------------------------
    // Stage outputs gathered into module-level vectors/arrays.
    // ------------------------------------------------------------------
    logic [STAGES-1:0] w_v;
    logic [STAGES-1:0] w_zero_q;
    logic [STAGES-1:0] w_par_q;
    logic [WIDTH-1:0]  w_res_q [STAGES];
    logic [TAG_W-1:0]  w_tag_q [STAGES];

    // Stage k may load when any stage from k to the last is empty, or when
    // the last stage is draining. Writing it as a reduction over the tail of
    // w_v avoids a ripple chain of load terms and lets bubbles collapse.
    logic [STAGES-1:0] w_load;
    logic              w_in_ready;
    logic              w_in_fire;

    genvar g;
    generate
        for (g = 0; g < STAGES; g++) begin : g_load
            assign w_load[g] = out_ready | ~(&w_v[STAGES-1:g]);
        end
    endgenerate

    // Nothing is accepted in a flush cycle.
    assign w_in_ready = w_load[0] & ~flush;
    assign w_in_fire  = in_valid & w_in_ready;

    // ------------------------------------------------------------------
    // Pipeline stages. Stage 0 captures the computed values; later stages
    // copy their upstream neighbour. Data registers update only when the
    // stage loads; a stage that loads an empty slot may hold stale data,
    // which its cleared valid bit masks.
    // ------------------------------------------------------------------
    generate
        for (g = 0; g < STAGES; g++) begin : g_stage
            logic             r_v;
            logic [WIDTH-1:0] r_res;
            logic             r_zero;
            logic             r_par;
            logic [TAG_W-1:0] r_tag;

            logic             w_v_in;
            logic [WIDTH-1:0] w_res_in;
            logic             w_zero_in;
            logic             w_par_in;
            logic [TAG_W-1:0] w_tag_in;

            if (g == 0) begin : g_head
                assign w_v_in    = w_in_fire;
                assign w_res_in  = w_res;
                assign w_zero_in = w_zero;
                assign w_par_in  = w_par;
                assign w_tag_in  = in_tag;
            end else begin : g_body
                assign w_v_in    = w_v[g-1];
                assign w_res_in  = w_res_q[g-1];
                assign w_zero_in = w_zero_q[g-1];
                assign w_par_in  = w_par_q[g-1];
                assign w_tag_in  = w_tag_q[g-1];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_v    <= 1'b0;
                    r_res  <= '0;
                    r_zero <= 1'b0;
                    r_par  <= 1'b0;
                    r_tag  <= '0;
                end else begin
                    if (flush) begin
                        r_v <= 1'b0;
                    end else if (w_load[g]) begin
                        r_v <= w_v_in;
                    end
                    if (w_load[g]) begin
                        r_res  <= w_res_in;
                        r_zero <= w_zero_in;
                        r_par  <= w_par_in;
                        r_tag  <= w_tag_in;
                    end
                end
            end

            assign w_v[g]      = r_v;
            assign w_res_q[g]  = r_res;
            assign w_zero_q[g] = r_zero;
            assign w_par_q[g]  = r_par;
            assign w_tag_q[g]  = r_tag;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Outputs come straight from the last stage.
    // ------------------------------------------------------------------
    assign in_ready  = w_in_ready;
    assign out_valid = w_v[STAGES-1];
    assign result    = w_res_q[STAGES-1];
    assign zero      = w_zero_q[STAGES-1];
    assign parity    = w_par_q[STAGES-1];
    assign out_tag   = w_tag_q[STAGES-1];
    assign busy      = |w_v;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Testbench for logic_unit_pipe. Index 0 drives a STAGES=2 instance, index 1 a
// STAGES=4 instance. Drivers push expected words into per-instance queues at
// acceptance; a negedge monitor pops and compares on every output transfer.
module tb_logic_unit_pipe;

    localparam int WIDTH = 32;
    localparam int TAG_W = 4;
    localparam int EW    = TAG_W + 2 + WIDTH;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic             flush     [2];
    logic             in_valid  [2];
    logic             in_ready  [2];
    logic [2:0]       op        [2];
    logic [WIDTH-1:0] a         [2];
    logic [WIDTH-1:0] b         [2];
    logic [TAG_W-1:0] in_tag    [2];
    logic             out_valid [2];
    logic             out_ready [2];
    logic [WIDTH-1:0] result    [2];
    logic             zero      [2];
    logic             parity    [2];
    logic [TAG_W-1:0] out_tag   [2];
    logic             busy      [2];

    logic_unit_pipe #(.WIDTH(WIDTH), .STAGES(2), .TAG_W(TAG_W)) u_dut_s2 (
        .clk(clk), .rst_n(rst_n), .flush(flush[0]),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .op(op[0]),
        .a(a[0]), .b(b[0]), .in_tag(in_tag[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .result(result[0]),
        .zero(zero[0]), .parity(parity[0]), .out_tag(out_tag[0]), .busy(busy[0])
    );

    logic_unit_pipe #(.WIDTH(WIDTH), .STAGES(4), .TAG_W(TAG_W)) u_dut_s4 (
        .clk(clk), .rst_n(rst_n), .flush(flush[1]),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .op(op[1]),
        .a(a[1]), .b(b[1]), .in_tag(in_tag[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .result(result[1]),
        .zero(zero[1]), .parity(parity[1]), .out_tag(out_tag[1]), .busy(busy[1])
    );

    // ---------------- scoreboard state ----------------
    logic [EW-1:0] exp_q0[$];
    logic [EW-1:0] exp_q1[$];
    int checks = 0;
    int errors = 0;
    int acc_cnt [2];
    int run0 = 0;
    int max_run0 = 0;
    logic [EW-1:0] prev_out  [2];
    logic [70:0]   prev_in   [2];
    bit            prev_stall[2];
    bit            prev_hold [2];
    logic [31:0]   exp3 [8];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [EW-1:0] pack_exp(input logic [31:0] r, input logic [3:0] t);
        return {t, ^r, (r == 32'h0), r};
    endfunction

    function automatic int qsize(input int d);
        return (d == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    // ---------------- driver tasks ----------------
    task automatic send(input int d, input logic [2:0] o, input logic [31:0] av,
                        input logic [31:0] bv, input logic [3:0] tg, input logic [31:0] er);
        bit done = 1'b0;
        @(posedge clk); #1;
        in_valid[d] = 1'b1; op[d] = o; a[d] = av; b[d] = bv; in_tag[d] = tg;
        for (int t = 0; t < 100 && !done; t++) begin
            @(negedge clk);
            if (in_ready[d]) begin
                if (d == 0) exp_q0.push_back(pack_exp(er, tg));
                else        exp_q1.push_back(pack_exp(er, tg));
                acc_cnt[d]++;
                done = 1'b1;
            end else begin
                @(posedge clk);
            end
        end
        if (!done) check($sformatf("accept_timeout_d%0d", d), {127'd0, done}, 128'd1);
    endtask

    task automatic idle(input int d);
        @(posedge clk); #1;
        in_valid[d] = 1'b0;
    endtask

    task automatic drain(input int d);
        int t = 0;
        while (qsize(d) != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check($sformatf("drain_d%0d", d), qsize(d), 0);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [EW-1:0] cur;
        logic [EW-1:0] exp_v;
        logic [70:0]   cur_in;
        for (int d = 0; d < 2; d++) begin
            cur    = {out_tag[d], parity[d], zero[d], result[d]};
            cur_in = {op[d], a[d], b[d], in_tag[d]};
            if (!rst_n) begin
                prev_stall[d] = 1'b0;
                prev_hold[d]  = 1'b0;
                if (d == 0) run0 = 0;
            end else begin
                if (prev_stall[d])
                    check($sformatf("stall_hold_d%0d", d), {out_valid[d], cur}, {1'b1, prev_out[d]});
                if (prev_hold[d])
                    check($sformatf("src_hold_d%0d", d), {in_valid[d], cur_in}, {1'b1, prev_in[d]});
                if (out_valid[d] && out_ready[d]) begin
                    if (qsize(d) == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_out_d%0d actual=%0h required=no output", d, cur);
                    end else begin
                        if (d == 0) exp_v = exp_q0.pop_front();
                        else        exp_v = exp_q1.pop_front();
                        check($sformatf("out_d%0d", d), cur, exp_v);
                    end
                end
                if (d == 0) begin
                    if (out_valid[0] && out_ready[0]) begin
                        run0++;
                        if (run0 > max_run0) max_run0 = run0;
                    end else begin
                        run0 = 0;
                    end
                end
                prev_stall[d] = out_valid[d] && !out_ready[d] && !flush[d];
                prev_hold[d]  = in_valid[d] && !in_ready[d] && !flush[d];
                prev_out[d]   = cur;
                prev_in[d]    = cur_in;
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        // AND of F0F0F0F0/FF00FF00 is F000F000, so NAND is 0FFF0FFF.
        exp3 = '{32'hF000F000, 32'hFFF0FFF0, 32'h0FF00FF0, 32'hF00FF00F,
                 32'h000F000F, 32'h0FFF0FFF, 32'h00F000F0, 32'hF0F0F0F0};
        for (int d = 0; d < 2; d++) begin
            flush[d] = 1'b0; in_valid[d] = 1'b0; op[d] = '0; a[d] = '0; b[d] = '0;
            in_tag[d] = '0; out_ready[d] = 1'b1; acc_cnt[d] = 0;
            prev_stall[d] = 1'b0; prev_hold[d] = 1'b0;
        end

        // 1. reset values and release
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid[0], 0);
        check("rst_busy",      busy[0], 0);
        check("rst_result",    result[0], 0);
        check("rst_flags",     {zero[0], parity[0]}, 0);
        check("rst_out_tag",   out_tag[0], 0);
        check("rst_busy_s4",   busy[1], 0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_release", {in_ready[0], in_ready[1]}, 2'b11);

        // mid-cycle reset with an op held in the pipe
        @(posedge clk); #1;
        out_ready[0] = 1'b0;
        send(0, 3'b001, 32'h0000_00F0, 32'h0000_000F, 4'd3, 32'h0000_00FF);
        idle(0);
        repeat (3) @(negedge clk);
        check("pre_reset_valid", out_valid[0], 1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", out_valid[0], 0);
        check("async_rst_busy",  busy[0], 0);
        check("async_rst_data",  {result[0], out_tag[0]}, 0);
        exp_q0.delete();
        exp_q1.delete();
        @(posedge clk); #3;
        rst_n = 1'b1;
        out_ready[0] = 1'b1;
        @(negedge clk);
        check("ready_after_rst2", in_ready[0], 1);

        // 2. single XOR, latency of two cycles
        send(0, 3'b010, 32'h0F0F00FF, 32'hF0FA00FF, 4'd5, 32'hFFF50000);
        idle(0);
        @(negedge clk);
        check("lat_cycle1", out_valid[0], 0);
        @(negedge clk);
        check("lat_cycle2", out_valid[0], 1);
        check("xor_direct", {result[0], zero[0], parity[0], out_tag[0]},
              {32'hFFF50000, 1'b0, 1'b0, 4'd5});
        drain(0);

        // 3. all eight ops back-to-back
        max_run0 = 0;
        for (int i = 0; i < 8; i++)
            send(0, 3'(i), 32'hF0F0F0F0, 32'hFF00FF00, 4'(i), exp3[i]);
        idle(0);
        drain(0);
        check("stream_no_gaps", max_run0, 8);

        // 4. backpressure on the two-stage pipe
        @(posedge clk); #1;
        out_ready[0] = 1'b0;
        begin
            int base;
            base = acc_cnt[0];
            fork
                begin
                    for (int i = 0; i < 6; i++)
                        send(0, 3'b111, 32'h1000_0000 + i, ~32'(i), 4'(i + 8), 32'h1000_0000 + i);
                    idle(0);
                end
                begin
                    repeat (8) @(negedge clk);
                    check("bp_in_ready_low", in_ready[0], 0);
                    check("bp_two_accepted", acc_cnt[0] - base, 2);
                    @(posedge clk); #1;
                    out_ready[0] = 1'b1;
                end
            join
        end
        drain(0);

        // 5. flags
        send(0, 3'b010, 32'hA5A5A5A5, 32'hA5A5A5A5, 4'd1, 32'h0000_0000);
        send(0, 3'b111, 32'h0000_0001, 32'hFFFF_FFFF, 4'd2, 32'h0000_0001);
        send(0, 3'b100, 32'h0000_0000, 32'h0000_0000, 4'd3, 32'hFFFF_FFFF);
        idle(0);
        drain(0);

        // 6a. flush with three ops held in the four-stage pipe
        @(posedge clk); #1;
        out_ready[1] = 1'b0;
        for (int i = 0; i < 3; i++)
            send(1, 3'b111, 32'h0000_AB00 + i, 32'h0, 4'(i + 1), 32'h0000_AB00 + i);
        idle(1);
        repeat (2) @(negedge clk);
        check("s4_busy_before_flush", busy[1], 1);
        @(posedge clk); #1;
        flush[1] = 1'b1;
        @(negedge clk);
        check("flush_in_ready", in_ready[1], 0);
        @(posedge clk); #1;
        flush[1] = 1'b0;
        exp_q1.delete();
        out_ready[1] = 1'b1;
        @(negedge clk);
        check("flush_busy",  busy[1], 0);
        check("flush_valid", out_valid[1], 0);
        repeat (6) @(negedge clk);
        send(1, 3'b010, 32'h12345678, 32'hFFFF0000, 4'd9, 32'hEDCB5678);
        idle(1);
        drain(1);

        // 6b. same with a reset pulse
        @(posedge clk); #1;
        out_ready[1] = 1'b0;
        for (int i = 0; i < 3; i++)
            send(1, 3'b000, 32'hFFFF_FFFF, 32'h0000_CD00 + i, 4'(i + 4), 32'h0000_CD00 + i);
        idle(1);
        repeat (2) @(negedge clk);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy",  busy[1], 0);
        check("rst_mid_valid", out_valid[1], 0);
        exp_q1.delete();
        @(posedge clk); #3;
        rst_n = 1'b1;
        out_ready[1] = 1'b1;
        repeat (6) @(negedge clk);
        send(1, 3'b110, 32'hFFFFFFFF, 32'h0F0F0F0F, 4'd12, 32'hF0F0F0F0);
        idle(1);
        drain(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
